// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID types: the buffered word layout and the NOP driven when empty.
package if_id_buffer_pkg;

  localparam int INSTR_W  = 32;
  localparam int BUNDLE_W = 26;

  // ori $zero,$zero,0 -- architecturally a no-op, shown to decode when empty
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h3400_0000;

  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [BUNDLE_W-1:0] bundle;
    logic [INSTR_W-1:0]  pc_seq;
  } if_id_word_t;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry IF/ID skid buffer: head slot feeds decode, skid slot absorbs one
// extra fetched word while decode stalls. Flush drops everything held.
module if_id_buffer #(
  parameter int DATA_W      = 32,
  parameter int BUNDLE_W    = 26,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      instr_in,
  input  logic [BUNDLE_W-1:0]    bundle_in,
  input  logic [DATA_W-1:0]      pc_seq_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      instruction_out,
  output logic [BUNDLE_W-1:0]    bundle_out,
  output logic [DATA_W-1:0]      pc_seq_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STALL_CNT_W-1:0] stall_count
);

  import if_id_buffer_pkg::*;

  if_id_word_t head_q, head_d;
  if_id_word_t skid_q, skid_d;
  logic        head_vld_q, head_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic        push;
  logic        pop;
  if_id_word_t in_word;

  // Skid is only ever filled behind a valid head, so count==2 means both valid.
  assign in_ready = !(head_vld_q && skid_vld_q);
  assign push     = in_valid && in_ready;
  assign pop      = head_vld_q && out_ready;

  assign in_word.instr  = instr_in;
  assign in_word.bundle = bundle_in;
  assign in_word.pc_seq = pc_seq_in;

  // Outputs come straight from registered state; empty shows NOP / zeros.
  assign out_valid       = head_vld_q;
  assign instruction_out = head_vld_q ? head_q.instr  : NOP_INSTR;
  assign bundle_out      = head_vld_q ? head_q.bundle : '0;
  assign pc_seq_out      = head_vld_q ? head_q.pc_seq : '0;
  assign stall_count     = stall_cnt_q;

  // Next-state for slot contents, slot valids and the saturating stall counter.
  always_comb begin
    head_d      = head_q;
    skid_d      = skid_q;
    head_vld_d  = head_vld_q;
    skid_vld_d  = skid_vld_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      // A concurrent pop counts as done and a concurrent push is dropped.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (pop) begin
        if (skid_vld_q) begin
          head_d     = skid_q;
          head_vld_d = 1'b1;
          skid_vld_d = 1'b0;
        end else begin
          head_vld_d = 1'b0;
        end
      end
      if (push) begin
        // Head takes the word if it is free now or vacated by this pop.
        if (!head_vld_q || (pop && !skid_vld_q)) begin
          head_d     = in_word;
          head_vld_d = 1'b1;
        end else begin
          skid_d     = in_word;
          skid_vld_d = 1'b1;
        end
      end
    end

    // Stall statistic survives flush; only reset clears it.
    if (head_vld_q && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  end

  // Control state: slot valids and stall counter, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      skid_vld_q  <= skid_vld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Slot payloads: no reset needed, outputs are masked by the valid bits.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

endmodule
